// File: rtl/dp_pkg.sv
// Shared types, default widths and the parity helper for the data-plane FIFO block.
package dp_pkg;

  localparam int DP_DATA_W       = 16;
  localparam int DP_ID_W         = 16;
  localparam int DP_DEPTH        = 8;
  localparam int DP_PARITY_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  // Callers zero-extend narrower vectors; zero bits do not change the XOR.
  function automatic logic dp_parity(input logic [DP_PARITY_MAX_W-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/dp_fifo.sv
// First-word-fall-through FIFO with full/empty/count; used for both the TX and RX queues.
module dp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/data_plane_fifo.sv
// Data-plane TX/RX queues with destination addressing and overflow reporting.
// Optional parity generation/checking is enabled by defining DATA_PLANE_PARITY_EN.
module data_plane_fifo
  import dp_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ID_W   = DP_ID_W,
  parameter int DEPTH  = DP_DEPTH,
  localparam int PKT_W = ID_W + DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   node_id,
  input  logic              gpp_trf_dp,
  input  logic [DATA_W-1:0] gpp_tx_data,
  input  logic [ID_W-1:0]   tx_dest_id,
  input  logic              data_tx_flag,
  output logic [PKT_W-1:0]  data_tx_packet,
  output logic              data_tx_valid,
  output logic              data_tx_complete_flag,
  output logic              tx_full,
  output logic [CW-1:0]     tx_count,
  output logic              tx_overflow,
  input  logic [PKT_W-1:0]  data_rx_packet,
  input  logic              data_rx_valid,
  input  logic              gpp_rtr_dp,
  output logic [DATA_W-1:0] RAM_rx_data_out,
  output logic              rx_empty,
  output logic              data_rx_complete_flag,
  output logic              rx_overflow,
  output logic              data_tx_parity,
  input  logic              data_rx_parity,
  output logic [7:0]        rx_err_count
);

  // ---------------- TX path ----------------
  tx_state_t         state_q, state_d;
  logic [ID_W-1:0]   dest_q, dest_d;
  logic [PKT_W-1:0]  tx_pkt_q, tx_pkt_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              tx_par_q, tx_par_d;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full_w;
  logic              tx_empty_w;
  logic [CW-1:0]     tx_count_w;
  logic              tx_pop;
  logic              tx_push_ok;

  assign tx_pop     = (state_q == SEND);
  assign tx_push_ok = gpp_trf_dp && (!tx_full_w || tx_pop);

  dp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (gpp_trf_dp),
    .wr_data (gpp_tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full_w),
    .empty   (tx_empty_w),
    .count   (tx_count_w)
  );

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    tx_pkt_d   = tx_pkt_q;
    tx_valid_d = 1'b0;
    tx_done_d  = 1'b0;
    tx_ovf_d   = tx_ovf_q | (gpp_trf_dp && tx_full_w && !tx_pop);
    case (state_q)
      IDLE: begin
        if (data_tx_flag) begin
          if (!tx_empty_w) begin
            dest_d  = tx_dest_id;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        tx_valid_d = 1'b1;
        tx_pkt_d   = {dest_q, tx_head};
        // A push landing on the last word keeps the burst going.
        if ((tx_count_w == CW'(1)) && !tx_push_ok) begin
          state_d = DONE;
        end
      end
      DONE: begin
        tx_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DATA_PLANE_PARITY_EN
    tx_par_d = dp_parity(DP_PARITY_MAX_W'(tx_pkt_d));
`else
    tx_par_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      tx_pkt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      tx_par_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      tx_pkt_q   <= tx_pkt_d;
      tx_valid_q <= tx_valid_d;
      tx_done_q  <= tx_done_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_par_q   <= tx_par_d;
    end
  end

  assign data_tx_packet        = tx_pkt_q;
  assign data_tx_valid         = tx_valid_q;
  assign data_tx_complete_flag = tx_done_q;
  assign data_tx_parity        = tx_par_q;
  assign tx_full               = tx_full_w;
  assign tx_count              = tx_count_w;
  assign tx_overflow           = tx_ovf_q;

  // ---------------- RX path ----------------
  logic              rx_match;
  logic              rx_par_ok;
  logic              rx_accept;
  logic              rx_pop;
  logic              rx_full_w;
  logic              rx_empty_w;
  logic [CW-1:0]     rx_count_unused;
  logic              rx_ovf_q, rx_ovf_d;
  logic              rx_run_q, rx_run_d;
  logic              rx_done_q, rx_done_d;
  logic [7:0]        rx_err_q, rx_err_d;

  assign rx_match = data_rx_valid && (data_rx_packet[PKT_W-1:DATA_W] == node_id);

`ifdef DATA_PLANE_PARITY_EN
  assign rx_par_ok = (dp_parity(DP_PARITY_MAX_W'(data_rx_packet)) == data_rx_parity);
`else
  logic unused_rx_parity;
  assign unused_rx_parity = data_rx_parity;
  assign rx_par_ok        = 1'b1;
`endif

  assign rx_accept = rx_match && rx_par_ok;
  assign rx_pop    = gpp_rtr_dp && !rx_empty_w;

  dp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_accept),
    .wr_data (data_rx_packet[DATA_W-1:0]),
    .pop     (gpp_rtr_dp),
    .rd_data (RAM_rx_data_out),
    .full    (rx_full_w),
    .empty   (rx_empty_w),
    .count   (rx_count_unused)
  );

  always_comb begin
    rx_ovf_d  = rx_ovf_q | (rx_accept && rx_full_w && !rx_pop);
    // The run remembers whether anything was accepted since valid last went low.
    rx_run_d  = data_rx_valid ? (rx_run_q | rx_accept) : 1'b0;
    rx_done_d = !data_rx_valid && rx_run_q;
    rx_err_d  = rx_err_q;
`ifdef DATA_PLANE_PARITY_EN
    if (rx_match && !rx_par_ok && (rx_err_q != 8'hFF)) begin
      rx_err_d = rx_err_q + 8'd1;
    end
`else
    rx_err_d = 8'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf_q  <= 1'b0;
      rx_run_q  <= 1'b0;
      rx_done_q <= 1'b0;
      rx_err_q  <= 8'd0;
    end else begin
      rx_ovf_q  <= rx_ovf_d;
      rx_run_q  <= rx_run_d;
      rx_done_q <= rx_done_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign rx_empty              = rx_empty_w;
  assign rx_overflow           = rx_ovf_q;
  assign data_rx_complete_flag = rx_done_q;
  assign rx_err_count          = rx_err_q;

endmodule

// File: tb/tb_data_plane_fifo.sv
// Self-checking bench for data_plane_fifo: table vectors, directed corner cases, random vs queue model.
module tb_data_plane_fifo;

  localparam int DATA_W = 16;
  localparam int ID_W   = 16;
  localparam int DEPTH  = 8;
  localparam int PKT_W  = 32;
  localparam int CW     = 4;

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   node_id;
  logic              gpp_trf_dp;
  logic [DATA_W-1:0] gpp_tx_data;
  logic [ID_W-1:0]   tx_dest_id;
  logic              data_tx_flag;
  logic [PKT_W-1:0]  data_tx_packet;
  logic              data_tx_valid;
  logic              data_tx_complete_flag;
  logic              tx_full;
  logic [CW-1:0]     tx_count;
  logic              tx_overflow;
  logic [PKT_W-1:0]  data_rx_packet;
  logic              data_rx_valid;
  logic              gpp_rtr_dp;
  logic [DATA_W-1:0] RAM_rx_data_out;
  logic              rx_empty;
  logic              data_rx_complete_flag;
  logic              rx_overflow;
  logic              data_tx_parity;
  logic              data_rx_parity;
  logic [7:0]        rx_err_count;

  data_plane_fifo #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .gpp_trf_dp            (gpp_trf_dp),
    .gpp_tx_data           (gpp_tx_data),
    .tx_dest_id            (tx_dest_id),
    .data_tx_flag          (data_tx_flag),
    .data_tx_packet        (data_tx_packet),
    .data_tx_valid         (data_tx_valid),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_full               (tx_full),
    .tx_count              (tx_count),
    .tx_overflow           (tx_overflow),
    .data_rx_packet        (data_rx_packet),
    .data_rx_valid         (data_rx_valid),
    .gpp_rtr_dp            (gpp_rtr_dp),
    .RAM_rx_data_out       (RAM_rx_data_out),
    .rx_empty              (rx_empty),
    .data_rx_complete_flag (data_rx_complete_flag),
    .rx_overflow           (rx_overflow),
    .data_tx_parity        (data_tx_parity),
    .data_rx_parity        (data_rx_parity),
    .rx_err_count          (rx_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpp_trf_dp     = 1'b0;
    gpp_tx_data    = '0;
    tx_dest_id     = '0;
    data_tx_flag   = 1'b0;
    data_rx_packet = '0;
    data_rx_valid  = 1'b0;
    gpp_rtr_dp     = 1'b0;
    data_rx_parity = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        push;
    logic [15:0] data;
    logic        flag;
    logic [15:0] dest;
    logic        exp_valid;
    logic [31:0] exp_pkt;
    logic        exp_comp;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vt[9];

  // Behavioural reference state for the random phase.
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  int          m_mode;   // 0 waiting for flag, 1 bursting, 2 pulse due
  logic [15:0] m_dest;
  logic        m_txovf, m_rxovf, m_run;
  int          m_err;

  initial begin
    int nsent;
    logic seen;
    node_id = 16'd3;
    do_reset();

    // Reset state.
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_valid", 32'(data_tx_valid), 32'd0);
    check("rst_tx_packet", data_tx_packet, 32'd0);
    check("rst_tx_comp", 32'(data_tx_complete_flag), 32'd0);
    check("rst_rx_comp", 32'(data_rx_complete_flag), 32'd0);
    check("rst_ovf", 32'({tx_overflow, rx_overflow}), 32'd0);
    check("rst_err", 32'(rx_err_count), 32'd0);

    // Basic burst: three words to destination 5.
    vt[0] = '{1'b1, 16'h0011, 1'b0, 16'h0, 1'b0, 32'h0,        1'b0, 4'd1};
    vt[1] = '{1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 32'h0,        1'b0, 4'd2};
    vt[2] = '{1'b1, 16'h0033, 1'b0, 16'h0, 1'b0, 32'h0,        1'b0, 4'd3};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 16'h5, 1'b0, 32'h0,        1'b0, 4'd3};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 32'h00050011, 1'b0, 4'd2};
    vt[5] = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 32'h00050022, 1'b0, 4'd1};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b1, 32'h00050033, 1'b0, 4'd0};
    vt[7] = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 32'h0,        1'b1, 4'd0};
    vt[8] = '{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 32'h0,        1'b0, 4'd0};
    for (int i = 0; i < 9; i++) begin
      gpp_trf_dp   = vt[i].push;
      gpp_tx_data  = vt[i].data;
      data_tx_flag = vt[i].flag;
      tx_dest_id   = vt[i].dest;
      step();
      check($sformatf("vec%0d_valid", i), 32'(data_tx_valid), 32'(vt[i].exp_valid));
      check($sformatf("vec%0d_comp", i), 32'(data_tx_complete_flag), 32'(vt[i].exp_comp));
      check($sformatf("vec%0d_count", i), 32'(tx_count), 32'(vt[i].exp_cnt));
      if (vt[i].exp_valid) check($sformatf("vec%0d_pkt", i), data_tx_packet, vt[i].exp_pkt);
    end
    $display("[TB] table burst done");

    // Overflow: nine pushes into an eight-deep queue, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      gpp_trf_dp  = 1'b1;
      gpp_tx_data = 16'h0100 + 16'(i);
      step();
      if (i == 6) check("ovf_full_at7", 32'(tx_full), 32'd0);
      if (i == 7) check("ovf_full_at8", 32'(tx_full), 32'd1);
      if (i == 7) check("ovf_flag_at8", 32'(tx_overflow), 32'd0);
      if (i == 8) check("ovf_flag_at9", 32'(tx_overflow), 32'd1);
    end
    check("ovf_count", 32'(tx_count), 32'd8);
    gpp_trf_dp   = 1'b0;
    data_tx_flag = 1'b1;
    tx_dest_id   = 16'h0007;
    step();
    data_tx_flag = 1'b0;
    nsent = 0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (data_tx_valid) begin
        check($sformatf("ovf_pkt%0d", nsent), data_tx_packet, {16'h0007, 16'h0100 + 16'(nsent)});
        nsent++;
      end
      if (data_tx_complete_flag) seen = 1'b1;
    end
    check("ovf_sent", 32'(nsent), 32'd8);
    check("ovf_comp_seen", 32'(seen), 32'd1);
    $display("[TB] overflow burst sent %0d packets", nsent);

    // RX filtering and ordering with node_id 3.
    do_reset();
    data_rx_valid  = 1'b1;
    data_rx_packet = 32'h00030AAA;
    step();
    check("rx_head_first", 32'(RAM_rx_data_out), 32'h0AAA);
    data_rx_packet = 32'h00040BBB;
    step();
    data_rx_packet = 32'h00030CCC;
    step();
    check("rx_comp_while_valid", 32'(data_rx_complete_flag), 32'd0);
    data_rx_valid = 1'b0;
    step();
    check("rx_comp_pulse", 32'(data_rx_complete_flag), 32'd1);
    step();
    check("rx_comp_clear", 32'(data_rx_complete_flag), 32'd0);
    check("rx_head0", 32'(RAM_rx_data_out), 32'h0AAA);
    gpp_rtr_dp = 1'b1;
    step();
    check("rx_head1", 32'(RAM_rx_data_out), 32'h0CCC);
    step();
    check("rx_empty_after", 32'(rx_empty), 32'd1);
    step();
    check("rx_pop_empty", 32'(rx_empty), 32'd1);
    check("rx_no_ovf", 32'(rx_overflow), 32'd0);
    gpp_rtr_dp = 1'b0;
    $display("[TB] rx ordering sequence done");

    // Flag with empty TX queue: no packet, single pulse two cycles on.
    do_reset();
    data_tx_flag = 1'b1;
    step();
    data_tx_flag = 1'b0;
    check("empty_burst_c1_comp", 32'(data_tx_complete_flag), 32'd0);
    check("empty_burst_c1_valid", 32'(data_tx_valid), 32'd0);
    step();
    check("empty_burst_c2_comp", 32'(data_tx_complete_flag), 32'd1);
    check("empty_burst_c2_valid", 32'(data_tx_valid), 32'd0);
    step();
    check("empty_burst_c3_comp", 32'(data_tx_complete_flag), 32'd0);
    $display("[TB] empty burst sequence done");

    // Reset in the middle of a five-word burst.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      gpp_trf_dp  = 1'b1;
      gpp_tx_data = 16'h0200 + 16'(i);
      step();
    end
    gpp_trf_dp   = 1'b0;
    data_tx_flag = 1'b1;
    tx_dest_id   = 16'h0009;
    step();
    data_tx_flag = 1'b0;
    step();
    check("midrst_pkt0", data_tx_packet, 32'h00090200);
    step();
    check("midrst_pkt1", data_tx_packet, 32'h00090201);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(data_tx_valid), 32'd0);
    check("midrst_packet", data_tx_packet, 32'd0);
    check("midrst_count", 32'(tx_count), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (data_tx_complete_flag || data_tx_valid) seen = 1'b1;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    $display("[TB] mid-burst reset sequence done");

`ifdef DATA_PLANE_PARITY_EN
    // Addressed packet with a wrong parity bit is dropped and counted.
    do_reset();
    data_rx_valid  = 1'b1;
    data_rx_packet = 32'h00030123;
    data_rx_parity = ~(^data_rx_packet);
    step();
    data_rx_valid = 1'b0;
    check("par_not_stored", 32'(rx_empty), 32'd1);
    check("par_err_count", 32'(rx_err_count), 32'd1);
    $display("[TB] parity error sequence done");
`endif

    // Random traffic against a queue-based model.
    do_reset();
    txq.delete();
    rxq.delete();
    m_mode  = 0;
    m_dest  = '0;
    m_txovf = 1'b0;
    m_rxovf = 1'b0;
    m_run   = 1'b0;
    m_err   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        exp_valid, exp_comp, exp_rxc, popped, rpop, match, ok;
      logic [31:0] exp_pkt;
      int          pre_size, rx_pre;
      gpp_trf_dp     = ($urandom_range(0, 9) < 6);
      gpp_tx_data    = 16'($urandom);
      data_tx_flag   = ($urandom_range(0, 9) == 0);
      tx_dest_id     = 16'($urandom_range(0, 15));
      data_rx_valid  = ($urandom_range(0, 9) < 6);
      data_rx_packet = {(($urandom_range(0, 9) < 7) ? 16'h0003 : 16'(16'h0004 + 16'($urandom_range(0, 3)))),
                        16'($urandom)};
      data_rx_parity = ($urandom_range(0, 3) == 0) ? ~(^data_rx_packet) : (^data_rx_packet);
      gpp_rtr_dp     = ($urandom_range(0, 3) == 0);

      exp_valid = 1'b0;
      exp_comp  = 1'b0;
      exp_pkt   = '0;
      popped    = 1'b0;
      pre_size  = txq.size();
      case (m_mode)
        2: begin
          exp_comp = 1'b1;
          m_mode   = 0;
        end
        0: begin
          if (data_tx_flag) begin
            if (pre_size > 0) begin
              m_mode = 1;
              m_dest = tx_dest_id;
            end else begin
              m_mode = 2;
            end
          end
        end
        default: begin
          exp_pkt   = {m_dest, txq.pop_front()};
          exp_valid = 1'b1;
          popped    = 1'b1;
        end
      endcase
      if (gpp_trf_dp) begin
        if (pre_size < DEPTH || popped) txq.push_back(gpp_tx_data);
        else m_txovf = 1'b1;
      end
      if (popped && txq.size() == 0) m_mode = 2;

      rx_pre = rxq.size();
      rpop   = 1'b0;
      if (gpp_rtr_dp && rx_pre > 0) begin
        void'(rxq.pop_front());
        rpop = 1'b1;
      end
      match = data_rx_valid && (data_rx_packet[31:16] == node_id);
`ifdef DATA_PLANE_PARITY_EN
      ok = match && ((^data_rx_packet) == data_rx_parity);
      if (match && !ok && m_err < 255) m_err++;
`else
      ok = match;
`endif
      if (ok) begin
        if (rx_pre < DEPTH || rpop) rxq.push_back(data_rx_packet[15:0]);
        else m_rxovf = 1'b1;
      end
      exp_rxc = !data_rx_valid && m_run;
      m_run   = data_rx_valid ? (m_run || ok) : 1'b0;

      step();
      check("rnd_tx_valid", 32'(data_tx_valid), 32'(exp_valid));
      if (exp_valid) check("rnd_tx_pkt", data_tx_packet, exp_pkt);
`ifdef DATA_PLANE_PARITY_EN
      if (exp_valid) check("rnd_tx_parity", 32'(data_tx_parity), 32'(^exp_pkt));
`else
      check("rnd_tx_parity", 32'(data_tx_parity), 32'd0);
`endif
      check("rnd_tx_comp", 32'(data_tx_complete_flag), 32'(exp_comp));
      check("rnd_tx_count", 32'(tx_count), 32'(txq.size()));
      check("rnd_tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
      check("rnd_tx_ovf", 32'(tx_overflow), 32'(m_txovf));
      check("rnd_rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
      if (rxq.size() > 0) check("rnd_rx_head", 32'(RAM_rx_data_out), 32'(rxq[0]));
      check("rnd_rx_ovf", 32'(rx_overflow), 32'(m_rxovf));
      check("rnd_rx_comp", 32'(data_rx_complete_flag), 32'(exp_rxc));
      check("rnd_rx_err", 32'(rx_err_count), 32'(m_err));
    end
    idle_inputs();
    $display("[TB] random phase done: tx_ovf=%0b rx_ovf=%0b", m_txovf, m_rxovf);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
